// File: rtl/puf_response_sequencer.sv
// rtl/puf_response_sequencer.sv - sequences one RO-race PUF subblock to build a multi-bit response
// Each bit: CLR (subblock reset) -> RUN (race) -> CAPTURE -> COOL; challenges from an 8-bit LFSR.
module puf_response_sequencer #(
   parameter int RESP_BITS  = 32,
   parameter int RST_CYCLES = 4,
   parameter int GAP_CYCLES = 2,
   parameter int TIMEOUT    = 16777216
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [7:0]           seed,
   output logic                 busy,
   output logic [7:0]           puf_challenge,
   output logic                 puf_enable,
   output logic                 puf_reset,
   input  logic                 puf_out,
   input  logic                 puf_done,
   output logic [RESP_BITS-1:0] resp,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic                 timeout_err
);

   localparam int CMAX = (RST_CYCLES > GAP_CYCLES) ? RST_CYCLES : GAP_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int WW   = $clog2(TIMEOUT + 1);
   localparam int BW   = $clog2(RESP_BITS + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_RUN,
      S_CAPTURE,
      S_COOL,
      S_DONE
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [7:0]    lfsr;
   logic [BW-1:0] bit_cnt;
   logic [WW-1:0] wait_cnt;
   logic [CW-1:0] cyc_cnt;
   logic          out_meta;
   logic          out_s;
   logic          done_meta;
   logic          done_s;
   logic          run_expired;

   assign puf_challenge = lfsr;
   assign run_expired   = (wait_cnt == WW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      busy       = 1'b1;
      puf_enable = 1'b0;
      puf_reset  = 1'b1;
      resp_valid = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = S_CLR;
         end
         S_CLR: begin
            if (cyc_cnt == CW'(RST_CYCLES - 1)) state_nxt = S_RUN;
         end
         S_RUN: begin
            puf_reset  = 1'b0;
            puf_enable = 1'b1;
            // a completed race beats an expiring timeout on the same cycle
            if (done_s)           state_nxt = S_CAPTURE;
            else if (run_expired) state_nxt = S_DONE;
         end
         S_CAPTURE: begin
            puf_reset  = 1'b0;
            puf_enable = 1'b1;
            state_nxt  = S_COOL;
         end
         S_COOL: begin
            if (cyc_cnt == CW'(GAP_CYCLES - 1))
               state_nxt = (bit_cnt == BW'(RESP_BITS)) ? S_DONE : S_CLR;
         end
         S_DONE: begin
            resp_valid = 1'b1;
            if (resp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_meta    <= 1'b0;
         out_s       <= 1'b0;
         done_meta   <= 1'b0;
         done_s      <= 1'b0;
         lfsr        <= 8'h00;
         bit_cnt     <= '0;
         wait_cnt    <= '0;
         cyc_cnt     <= '0;
         resp        <= '0;
         timeout_err <= 1'b0;
      end else begin
         out_meta  <= puf_out;
         out_s     <= out_meta;
         done_meta <= puf_done;
         done_s    <= done_meta;

         if (state_nxt != state)   cyc_cnt <= '0;
         else if (cyc_cnt != '1)   cyc_cnt <= cyc_cnt + CW'(1);

         if (state != S_RUN && state_nxt == S_RUN)     wait_cnt <= '0;
         else if (state == S_RUN && wait_cnt != '1)    wait_cnt <= wait_cnt + WW'(1);

         if (state == S_IDLE && start) begin
            lfsr        <= (seed == 8'h00) ? 8'h01 : seed;
            bit_cnt     <= '0;
            resp        <= '0;
            timeout_err <= 1'b0;
         end

         if (state == S_RUN && !done_s && run_expired) timeout_err <= 1'b1;

         if (state == S_CAPTURE) begin
            resp <= resp | (RESP_BITS'(out_s) << bit_cnt);
            if (bit_cnt != BW'(RESP_BITS)) bit_cnt <= bit_cnt + BW'(1);
            // x^8+x^6+x^5+x^4+1, never reaches zero from a nonzero state
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         end
      end
   end

endmodule

// File: tb/tb_puf_response_sequencer.sv
// tb/tb_puf_response_sequencer.sv - scoreboard bench for puf_response_sequencer with a behavioural subblock
module tb_puf_response_sequencer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] seed = 8'h00;
   logic       busy;
   logic [7:0] puf_challenge;
   logic       puf_enable;
   logic       puf_reset;
   logic       puf_out = 1'b0;
   logic       puf_done = 1'b0;
   logic [3:0] resp;
   logic       resp_valid;
   logic       resp_ready = 1'b0;
   logic       timeout_err;

   int checks = 0;
   int failures = 0;

   logic [7:0] chal_q[$];
   logic [4:0] resp_q[$];

   logic [3:0] out_tab = 4'h0;
   int         dly = 0;
   int         mbit = 0;
   int         run_cyc = 0;

   always #5 clk = ~clk;

   puf_response_sequencer #(
      .RESP_BITS(4),
      .RST_CYCLES(4),
      .GAP_CYCLES(2),
      .TIMEOUT(100)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .start(start),
      .seed(seed),
      .busy(busy),
      .puf_challenge(puf_challenge),
      .puf_enable(puf_enable),
      .puf_reset(puf_reset),
      .puf_out(puf_out),
      .puf_done(puf_done),
      .resp(resp),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .timeout_err(timeout_err)
   );

   // subblock model: done rises after dly enabled cycles, holds until puf_reset; dly==0 never finishes
   always @(negedge clk) begin
      if (!busy) mbit = 0;
      if (puf_reset) begin
         puf_done = 1'b0;
         run_cyc  = 0;
      end else if (puf_enable) begin
         run_cyc++;
         if (dly != 0 && !puf_done && run_cyc == dly) begin
            puf_out  = out_tab[mbit[1:0]];
            puf_done = 1'b1;
            mbit++;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      logic       prev_en = 1'b0;
      logic [7:0] ec;
      logic [4:0] er;
      forever begin
         @(negedge clk);
         if (puf_enable && !prev_en) begin
            if (chal_q.size() == 0) chk("chal_extra", 64'(chal_q.size()), 64'd1);
            else begin
               ec = chal_q.pop_front();
               chk("challenge", puf_challenge, ec);
            end
         end
         prev_en = puf_enable;
         if (resp_valid && resp_ready) begin
            if (resp_q.size() == 0) chk("resp_extra", 64'(resp_q.size()), 64'd1);
            else begin
               er = resp_q.pop_front();
               chk("resp_word", {timeout_err, resp}, er);
            end
         end
      end
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!resp_valid && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("resp_valid_seen", resp_valid, 1'b1);
   endtask

   task automatic run(input logic [7:0] s, input logic [3:0] outs, input int d,
                      input logic [31:0] chals, input int nchal, input logic [4:0] expr,
                      input bit hold);
      logic bad = 1'b0;
      out_tab = outs;
      dly = d;
      for (int i = 0; i < nchal; i++) chal_q.push_back(chals[8*i +: 8]);
      resp_q.push_back(expr);
      @(posedge clk); #1;
      seed  = s;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("busy_after_start", busy, 1'b1);
      chk("timeout_err_cleared", timeout_err, 1'b0);
      wait_valid();
      if (hold) begin
         for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            seed  = 8'h5A;
            start = (i % 10 == 0);
            @(negedge clk);
            if (!resp_valid || !busy || resp !== expr[3:0]) bad = 1'b1;
         end
         chk("hold_stable", bad, 1'b0);
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
      start      = hold;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      start      = 1'b0;
      @(negedge clk);
      chk("idle_after_accept", busy, 1'b0);
      if (hold) begin
         repeat (3) @(negedge clk);
         chk("start_ignored", busy, 1'b0);
      end
   endtask

   initial begin
      int n;
      fork
         monitor();
      join_none

      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_enable", puf_enable, 1'b0);
      chk("rst_puf_reset", puf_reset, 1'b1);
      chk("rst_challenge", puf_challenge, 8'h00);
      chk("rst_resp", resp, 4'h0);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_timeout_err", timeout_err, 1'b0);
      reset_n = 1'b1;

      run(8'h01, 4'b1101, 3, 32'h08040201, 4, 5'b0_1101, 1'b0);
      run(8'h00, 4'b0010, 5, 32'h08040201, 4, 5'b0_0010, 1'b0);
      run(8'hB8, 4'b1010, 1, 32'hC0E070B8, 4, 5'b0_1010, 1'b0);

      // race never finishes: abort after 100 RUN cycles with nothing captured
      run(8'h08, 4'b1111, 0, 32'h00000008, 1, 5'b1_0000, 1'b0);
      chk("timeout_err_held_idle", timeout_err, 1'b1);

      // done_s lands exactly on the last RUN cycle of the timeout window
      run(8'h08, 4'b0110, 98, 32'h47231108, 4, 5'b0_0110, 1'b0);

      run(8'h01, 4'b0101, 2, 32'h08040201, 4, 5'b0_0101, 1'b1);

      // reset during RUN of bit 2; that response is never delivered
      out_tab = 4'hF;
      dly = 4;
      chal_q.push_back(8'h01);
      chal_q.push_back(8'h02);
      chal_q.push_back(8'h04);
      @(posedge clk); #1;
      seed  = 8'h01;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (!(mbit == 2 && puf_enable && !puf_done) && n < 1000);
      chk("reached_bit2_run", (mbit == 2) && puf_enable, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("abort_enable", puf_enable, 1'b0);
      chk("abort_puf_reset", puf_reset, 1'b1);
      chk("abort_busy", busy, 1'b0);
      chk("abort_resp", resp, 4'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      run(8'h08, 4'b1001, 3, 32'h47231108, 4, 5'b0_1001, 1'b0);

      repeat (5) @(negedge clk);
      chk("chal_q_drained", 64'(chal_q.size()), 64'd0);
      chk("resp_q_drained", 64'(resp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
